// File: rtl/clkgate_pkg.sv
// Shared types and helpers for the multi-channel clock-gate controller.
//   cg_state_e  : per-channel gate state (run / hold-off countdown / off / wake settle)
//   wake_cnt_w  : width of the wake settle counter, never below one bit
package clkgate_pkg;

  typedef enum logic [1:0] {
    CG_RUN  = 2'd0,
    CG_HOLD = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_e;

  // Bits needed to hold WAKE_CYC; a zero-cycle wake still gets a 1-bit (unused) counter.
  function automatic int unsigned wake_cnt_w(input int unsigned wake_cyc);
    return (wake_cyc == 0) ? 1 : $clog2(wake_cyc + 1);
  endfunction

endpackage

// File: rtl/clkgate_chan.sv
// One clock-gate channel: turns a clock request into an ICG enable with a programmable
// switch-off delay and a fixed wake-up settle period before the channel reports ready.
// Ports:
//   clk_i       system clock, all state on posedge
//   rst_i       synchronous active-high reset, forces RUN
//   clken_i     clock request for this channel
//   force_on_i  global override: keep or bring the channel to RUN
//   dly_cfg_i   switch-off delay in cycles, sampled only when leaving RUN
//   gate_en_o   enable to the ICG cell
//   ready_o     clock running and settled
//   chan_off_o  channel is gated off
module clkgate_chan
  import clkgate_pkg::*;
#(
  parameter int unsigned DLY_W    = 4,
  parameter int unsigned WAKE_CYC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clken_i,
  input  logic             force_on_i,
  input  logic [DLY_W-1:0] dly_cfg_i,
  output logic             gate_en_o,
  output logic             ready_o,
  output logic             chan_off_o
);

  localparam int unsigned      WakeW    = wake_cnt_w(WAKE_CYC);
  localparam logic [WakeW-1:0] WakeLoad = WakeW'(WAKE_CYC);
  localparam logic [WakeW-1:0] WakeOne  = WakeW'(1);
  localparam logic [DLY_W-1:0] DlyOne   = DLY_W'(1);

  cg_state_e        state_q, state_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic             want_clk;

  // Either a functional request or the override keeps the clock alive.
  assign want_clk = clken_i | force_on_i;

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      CG_RUN: begin
        if (!want_clk) begin
          if (dly_cfg_i == '0) begin
            state_d = CG_OFF;
          end else begin
            // Delay is captured once here; later dly_cfg_i changes wait for the next RUN exit.
            state_d   = CG_HOLD;
            dly_cnt_d = dly_cfg_i;
          end
        end
      end
      CG_HOLD: begin
        if (want_clk) begin
          state_d   = CG_RUN;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == DlyOne) begin
          state_d   = CG_OFF;
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q - DlyOne;
        end
      end
      CG_OFF: begin
        if (want_clk) begin
          if (WAKE_CYC == 0) begin
            state_d = CG_RUN;
          end else begin
            state_d    = CG_WAKE;
            wake_cnt_d = WakeLoad;
          end
        end
      end
      CG_WAKE: begin
        // Settle always runs to completion so the gated clock never sees a short burst.
        if (wake_cnt_q == WakeOne) begin
          state_d    = CG_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - WakeOne;
        end
      end
      default: begin
        state_d    = CG_RUN;
        dly_cnt_d  = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CG_RUN;
      dly_cnt_q  <= '0;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  // Outputs depend on registered state only: no input-to-output path.
  always_comb begin
    gate_en_o  = 1'b1;
    ready_o    = 1'b1;
    chan_off_o = 1'b0;
    unique case (state_q)
      CG_RUN, CG_HOLD: begin
        gate_en_o = 1'b1;
        ready_o   = 1'b1;
      end
      CG_OFF: begin
        gate_en_o  = 1'b0;
        ready_o    = 1'b0;
        chan_off_o = 1'b1;
      end
      CG_WAKE: begin
        gate_en_o = 1'b1;
        ready_o   = 1'b0;
      end
      default: begin
        gate_en_o = 1'b1;
        ready_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/clkgate_ctrl.sv
// Multi-channel clock-gate controller. Each channel runs an independent gate FSM; this level
// only fans out the shared clock, reset and override and packs the per-channel outputs.
// Ports:
//   clk_i       system clock (must run during reset)
//   rst_i       synchronous active-high reset
//   clken_i     per-channel clock request
//   dly_cfg_i   per-channel switch-off delay, packed [NCH-1:0][DLY_W-1:0]
//   force_on_i  global override: all channels run, no new switch-off
//   gate_en_o   per-channel ICG enable
//   ready_o     per-channel clock running and settled
//   chan_off_o  per-channel gated-off indication
module clkgate_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DLY_W    = 4,
  parameter int unsigned WAKE_CYC = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NCH-1:0]            clken_i,
  input  logic [NCH-1:0][DLY_W-1:0] dly_cfg_i,
  input  logic                      force_on_i,
  output logic [NCH-1:0]            gate_en_o,
  output logic [NCH-1:0]            ready_o,
  output logic [NCH-1:0]            chan_off_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkgate_chan #(
      .DLY_W    (DLY_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clken_i    (clken_i[i]),
      .force_on_i (force_on_i),
      .dly_cfg_i  (dly_cfg_i[i]),
      .gate_en_o  (gate_en_o[i]),
      .ready_o    (ready_o[i]),
      .chan_off_o (chan_off_o[i])
    );
  end

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl (4 channels, 4-bit delay, 2-cycle wake). Each step drives
// inputs, takes one clock edge and compares {gate_en, ready, chan_off} as three hex nibbles.
module tb_clkgate_ctrl;

  logic            clk;
  logic            rst;
  logic [3:0]      clken;
  logic [3:0][3:0] dly_cfg;
  logic            force_on;
  logic [3:0]      gate_en;
  logic [3:0]      ready;
  logic [3:0]      chan_off;

  int n_cmp;
  int n_bad;

  clkgate_ctrl #(
    .NCH      (4),
    .DLY_W    (4),
    .WAKE_CYC (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clken_i    (clken),
    .dly_cfg_i  (dly_cfg),
    .force_on_i (force_on),
    .gate_en_o  (gate_en),
    .ready_o    (ready),
    .chan_off_o (chan_off)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset holds everything running; after release channels drop at edge t + delay.
  task automatic test_reset();
    logic [11:0] ex [5] = '{12'hFF0, 12'hDD2, 12'hCC3, 12'h887, 12'h00F};
    rst     = 1'b1;
    clken   = 4'h0;
    dly_cfg = 16'h4312;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== 12'hFF0) begin
        n_bad++;
        $display("FAIL reset hold %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, 12'hFF0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL reset release t+%0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
  endtask

  // Wake all from OFF, then ch0 delay 3 and ch1 delay 0 drop together.
  task automatic test_delay();
    logic [3:0]  ck [7] = '{4'hF, 4'hF, 4'hF, 4'hC, 4'hC, 4'hC, 4'hC};
    logic [11:0] ex [7] = '{12'hF00, 12'hF00, 12'hFF0, 12'hDD2, 12'hDD2, 12'hDD2, 12'hCC3};
    dly_cfg = 16'h5503;
    for (int k = 0; k < 7; k++) begin
      clken = ck[k];
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL delay step %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
  endtask

  // ch0 request returns during HOLD: gate never drops.
  task automatic test_hold_abort();
    logic [3:0]  ck [8] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};
    logic [11:0] ex [8] = '{12'hFC0, 12'hFC0, 12'hFF0, 12'hFF0,
                            12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0};
    dly_cfg = 16'h5503;
    for (int k = 0; k < 8; k++) begin
      clken = ck[k];
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL hold_abort step %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
  endtask

  // ch0 off, woken, request dropped mid-wake: wake completes, then HOLD of 2, then OFF.
  task automatic test_wake();
    logic [3:0]  ck [7] = '{4'hE, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
    logic [15:0] dl [7] = '{16'h5500, 16'h5500, 16'h5502, 16'h5502,
                            16'h5502, 16'h5502, 16'h5502};
    logic [11:0] ex [7] = '{12'hEE1, 12'hFE0, 12'hFE0, 12'hFF0, 12'hFF0, 12'hFF0, 12'hEE1};
    for (int k = 0; k < 7; k++) begin
      clken   = ck[k];
      dly_cfg = dl[k];
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL wake step %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
  endtask

  // All off, force wakes everything and blocks switch-off; release starts countdowns.
  task automatic test_force();
    logic        fo [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] ex [11] = '{12'h00F, 12'hF00, 12'hF00, 12'hFF0, 12'hFF0, 12'hFF0,
                             12'hFF0, 12'hDD2, 12'h996, 12'h887, 12'h00F};
    clken = 4'h0;
    for (int k = 0; k < 11; k++) begin
      force_on = fo[k];
      dly_cfg  = (k == 0) ? 16'h0000 : 16'h3102;
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL force step %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
  endtask

  // Reset with ch0 in HOLD and ch1 in WAKE; afterwards a latched delay ignores dly_cfg changes.
  task automatic test_reset_mid();
    logic [3:0]  ck [4] = '{4'hD, 4'hD, 4'hD, 4'hE};
    logic [11:0] ex [4] = '{12'hD02, 12'hD02, 12'hDD2, 12'hFD0};
    logic [11:0] ey [4] = '{12'hFF0, 12'hFF0, 12'hFF0, 12'hEE1};
    dly_cfg = 16'h5503;
    for (int k = 0; k < 4; k++) begin
      clken = ck[k];
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ex[k]) begin
        n_bad++;
        $display("FAIL reset_mid setup %0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ex[k]);
      end
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gate_en, ready, chan_off} !== 12'hFF0) begin
      n_bad++;
      $display("FAIL reset_mid reset edge: gate/ready/off got %h want %h",
               {gate_en, ready, chan_off}, 12'hFF0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dly_cfg = (k == 0) ? 16'h5503 : 16'h5501;
      tick();
      n_cmp++;
      if ({gate_en, ready, chan_off} !== ey[k]) begin
        n_bad++;
        $display("FAIL reset_mid latch t+%0d: gate/ready/off got %h want %h", k,
                 {gate_en, ready, chan_off}, ey[k]);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    clken    = 4'h0;
    dly_cfg  = '0;
    force_on = 1'b0;
    n_cmp    = 0;
    n_bad    = 0;
    test_reset();
    test_delay();
    test_hold_abort();
    test_wake();
    test_force();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
